// File: rtl/elevator_call_panel_if.sv
// Call-panel signal bundle: button/car-status inputs and request-bus/lamp outputs.
// master = controller/test side, slave = the call panel.
interface elevator_call_panel_if #(
  parameter int NUM_FLOORS = 16
);
  logic [NUM_FLOORS-1:0] call_btn;
  logic [3:0]            current_floor;
  logic                  door_open;
  logic [3:0]            requested_floor;
  logic [NUM_FLOORS-1:0] call_lamp;
  logic [NUM_FLOORS-1:0] issued;
  logic [4:0]            outstanding;
  logic                  busy;

  modport master (
    output call_btn, current_floor, door_open,
    input  requested_floor, call_lamp, issued, outstanding, busy
  );

  modport slave (
    input  call_btn, current_floor, door_open,
    output requested_floor, call_lamp, issued, outstanding, busy
  );
endinterface

// File: rtl/elevator_call_panel.sv
// Latches call buttons, serialises pending calls onto requested_floor (one change = one request).
// Press reaches call_lamp 3 clk after the raw edge; issue rate bounded by HOLD and MAX_OUTSTANDING.
module elevator_call_panel #(
  parameter int NUM_FLOORS      = 16,
  parameter int HOLD_CYCLES     = 2,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  elevator_call_panel_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, HOLD} state_t;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t                state_q, state_d;
  logic [3:0]            scan_ptr_q, scan_ptr_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [3:0]            req_q, req_d;
  logic [4:0]            outst_q, outst_d;
  logic [NUM_FLOORS-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_FLOORS-1:0] lamp_q, lamp_d, issued_q, issued_d;
  logic [NUM_FLOORS-1:0] press, serve_mask, cand, issue_mask;
  logic                  serve, inc, dec;

  function automatic logic [3:0] next_floor(input logic [3:0] f);
    return (f == 4'(NUM_FLOORS - 1)) ? 4'd0 : f + 4'd1;
  endfunction

  assign serve = bus.door_open && ({1'b0, bus.current_floor} < 5'(NUM_FLOORS));
  assign press = sync2_q & ~prev_q;

  always_comb begin
    serve_mask = '0;
    cand       = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      serve_mask[f] = serve && (bus.current_floor == 4'(f));
      // The floor already on the bus cannot be re-requested until the bus moves on.
      cand[f]       = lamp_q[f] && !issued_q[f] && (req_q != 4'(f));
    end
  end

  always_comb begin
    state_d    = state_q;
    scan_ptr_d = scan_ptr_q;
    hold_d     = hold_q;
    req_d      = req_q;
    issue_mask = '0;
    case (state_q)
      IDLE: begin
        if (|cand && (outst_q < 5'(MAX_OUTSTANDING))) begin
          state_d    = SCAN;
          scan_ptr_d = next_floor(req_q);
        end
      end
      SCAN: begin
        if (cand == '0)
          state_d = IDLE;
        else if (cand[scan_ptr_q])
          state_d = ISSUE;
        else
          scan_ptr_d = next_floor(scan_ptr_q);
      end
      ISSUE: begin
        // Abort if the call was served (now or on the SCAN->ISSUE edge) before it went out.
        if (serve_mask[scan_ptr_q] || !cand[scan_ptr_q]) begin
          state_d = IDLE;
        end else begin
          req_d                  = scan_ptr_q;
          issue_mask[scan_ptr_q] = 1'b1;
          hold_d                 = '0;
          state_d                = HOLD;
        end
      end
      HOLD: begin
        if (hold_q == HW'(HOLD_CYCLES - 1))
          state_d = IDLE;
        else
          hold_d = hold_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lamp_d   = (lamp_q | press) & ~serve_mask;
    issued_d = (issued_q | issue_mask) & ~serve_mask;
    inc      = |issue_mask;
    dec      = |(serve_mask & issued_q);
    outst_d  = outst_q + 5'(inc) - 5'(dec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      lamp_q     <= '0;
      issued_q   <= '0;
      outst_q    <= '0;
      req_q      <= '0;
      state_q    <= IDLE;
      scan_ptr_q <= '0;
      hold_q     <= '0;
    end else begin
      sync1_q    <= bus.call_btn;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      lamp_q     <= lamp_d;
      issued_q   <= issued_d;
      outst_q    <= outst_d;
      req_q      <= req_d;
      state_q    <= state_d;
      scan_ptr_q <= scan_ptr_d;
      hold_q     <= hold_d;
    end
  end

  assign bus.requested_floor = req_q;
  assign bus.call_lamp       = lamp_q;
  assign bus.issued          = issued_q;
  assign bus.outstanding     = outst_q;
  assign bus.busy            = (state_q != IDLE);
endmodule
